// File: rtl/led_gpio_pkg.sv
// Shared definitions for the LED/GPIO peripheral: register map, CTRL bits,
// register-select enum and small bus helpers.
package led_gpio_pkg;

    localparam logic [7:0] OFF_CTRL       = 8'h00;
    localparam logic [7:0] OFF_LED_OUT    = 8'h10;
    localparam logic [7:0] OFF_LED_SET    = 8'h14;
    localparam logic [7:0] OFF_LED_CLR    = 8'h18;
    localparam logic [7:0] OFF_PRESCALE   = 8'h1C;
    localparam logic [7:0] OFF_DUTY       = 8'h20;
    localparam logic [7:0] OFF_BLINK_MASK = 8'h24;

    localparam int CTRL_PWM_EN   = 0;
    localparam int CTRL_BLINK_EN = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_LED_OUT,
        SEL_LED_SET,
        SEL_LED_CLR,
        SEL_PRESCALE,
        SEL_DUTY,
        SEL_BLINK_MASK
    } reg_sel_e;

    // Misaligned offsets never match a table entry, so they fall to SEL_NONE.
    function automatic reg_sel_e decode_sel(input logic [7:0] off);
        reg_sel_e sel;
        sel = SEL_NONE;
        case (off)
            OFF_CTRL:       sel = SEL_CTRL;
            OFF_LED_OUT:    sel = SEL_LED_OUT;
            OFF_LED_SET:    sel = SEL_LED_SET;
            OFF_LED_CLR:    sel = SEL_LED_CLR;
            OFF_PRESCALE:   sel = SEL_PRESCALE;
            OFF_DUTY:       sel = SEL_DUTY;
            OFF_BLINK_MASK: sel = SEL_BLINK_MASK;
            default:        sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (wdata & mask);
    endfunction

endpackage

// File: rtl/led_gpio_if.sv
// Ibex-style data bus between the system interconnect and the LED peripheral.
interface led_gpio_if;

    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/led_pwm_gen.sv
// Free-running timebase: prescaler tick, PWM counter and blink phase.
// BlinkDivLog2 must be at least 1.
module led_pwm_gen #(
    parameter int PrescalerWidth = 16,
    parameter int PwmWidth       = 8,
    parameter int BlinkDivLog2   = 6
) (
    input  logic                      clk_sys,
    input  logic                      rst_sys_n,
    input  logic [PrescalerWidth-1:0] prescale,
    input  logic [PwmWidth-1:0]       duty,
    input  logic                      clr_prescaler,
    output logic                      pwm_on,
    output logic                      blink_phase
);

    logic [PrescalerWidth-1:0] presc_cnt_reg, presc_cnt_next;
    logic [PwmWidth-1:0]       pwm_cnt_reg, pwm_cnt_next;
    logic [BlinkDivLog2-1:0]   blink_cnt_reg, blink_cnt_next;
    logic                      blink_phase_reg, blink_phase_next;
    logic                      tick;
    logic                      pwm_wrap;

    assign tick     = (presc_cnt_reg == prescale);
    assign pwm_wrap = tick & (&pwm_cnt_reg);

    always_comb begin
        presc_cnt_next   = presc_cnt_reg + 1'b1;
        pwm_cnt_next     = pwm_cnt_reg;
        blink_cnt_next   = blink_cnt_reg;
        blink_phase_next = blink_phase_reg;
        // A new PRESCALE value restarts the period from zero.
        if (clr_prescaler || tick) begin
            presc_cnt_next = '0;
        end
        if (tick) begin
            pwm_cnt_next = pwm_cnt_reg + 1'b1;
        end
        if (pwm_wrap) begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
            if (&blink_cnt_reg) begin
                blink_phase_next = ~blink_phase_reg;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            presc_cnt_reg   <= '0;
            pwm_cnt_reg     <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            presc_cnt_reg   <= presc_cnt_next;
            pwm_cnt_reg     <= pwm_cnt_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
        end
    end

    // All-ones duty means always on so the brightest level has no dark slot.
    assign pwm_on      = (pwm_cnt_reg < duty) | (&duty);
    assign blink_phase = blink_phase_reg;

endmodule

// File: rtl/led_gpio_periph.sv
// Memory-mapped LED driver with per-LED PWM dimming and blink gating.
// With CTRL = 0 it behaves as a plain registered LED output register.
module led_gpio_periph
    import led_gpio_pkg::*;
#(
    parameter int NumLeds        = 8,
    parameter int PrescalerWidth = 16,
    parameter int PwmWidth       = 8,
    parameter int BlinkDivLog2   = 6
) (
    input  logic               clk_sys,
    input  logic               rst_sys_n,
    led_gpio_if.slave          bus,
    output logic [NumLeds-1:0] led_o
);

    reg_sel_e                  sel;
    logic [31:0]               be_mask;
    logic [31:0]               wdata_m;
    logic [31:0]               rd_mux;
    logic                      wr_en;
    logic                      prescale_clr;
    logic                      pwm_on;
    logic                      blink_phase;
    logic                      unused_addr;

    logic [1:0]                ctrl_reg, ctrl_next;
    logic [NumLeds-1:0]        led_out_reg, led_out_next;
    logic [NumLeds-1:0]        blink_mask_reg, blink_mask_next;
    logic [PrescalerWidth-1:0] prescale_reg, prescale_next;
    logic [PwmWidth-1:0]       duty_reg, duty_next;
    logic [NumLeds-1:0]        led_reg, led_next;
    logic                      rvalid_reg;
    logic                      err_reg;
    logic [31:0]               rdata_reg;

    // The interconnect has already decoded the upper address bits into req_i.
    assign unused_addr  = ^bus.addr_i[31:8];

    assign sel          = decode_sel(bus.addr_i[7:0]);
    assign be_mask      = be_to_mask(bus.be_i);
    assign wdata_m      = bus.wdata_i & be_mask;
    assign wr_en        = bus.req_i & bus.we_i;
    assign prescale_clr = wr_en & (sel == SEL_PRESCALE) & (|bus.be_i);

    always_comb begin
        ctrl_next       = ctrl_reg;
        led_out_next    = led_out_reg;
        blink_mask_next = blink_mask_reg;
        prescale_next   = prescale_reg;
        duty_next       = duty_reg;
        if (wr_en) begin
            case (sel)
                SEL_CTRL:       ctrl_next = 2'(merge_bytes(32'(ctrl_reg), bus.wdata_i, be_mask));
                SEL_LED_OUT:    led_out_next = NumLeds'(merge_bytes(32'(led_out_reg), bus.wdata_i, be_mask));
                SEL_LED_SET:    led_out_next = led_out_reg | NumLeds'(wdata_m);
                SEL_LED_CLR:    led_out_next = led_out_reg & ~NumLeds'(wdata_m);
                SEL_PRESCALE:   prescale_next = PrescalerWidth'(merge_bytes(32'(prescale_reg), bus.wdata_i, be_mask));
                SEL_DUTY:       duty_next = PwmWidth'(merge_bytes(32'(duty_reg), bus.wdata_i, be_mask));
                SEL_BLINK_MASK: blink_mask_next = NumLeds'(merge_bytes(32'(blink_mask_reg), bus.wdata_i, be_mask));
                default:        ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_CTRL:       rd_mux = 32'(ctrl_reg);
            SEL_LED_OUT:    rd_mux = 32'(led_out_reg);
            SEL_PRESCALE:   rd_mux = 32'(prescale_reg);
            SEL_DUTY:       rd_mux = 32'(duty_reg);
            SEL_BLINK_MASK: rd_mux = 32'(blink_mask_reg);
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ctrl_reg       <= '0;
            led_out_reg    <= '0;
            blink_mask_reg <= '0;
            prescale_reg   <= '0;
            duty_reg       <= '0;
            led_reg        <= '0;
            rvalid_reg     <= 1'b0;
            err_reg        <= 1'b0;
            rdata_reg      <= '0;
        end else begin
            ctrl_reg       <= ctrl_next;
            led_out_reg    <= led_out_next;
            blink_mask_reg <= blink_mask_next;
            prescale_reg   <= prescale_next;
            duty_reg       <= duty_next;
            led_reg        <= led_next;
            rvalid_reg     <= bus.req_i;
            err_reg        <= bus.req_i & (sel == SEL_NONE);
            rdata_reg      <= (bus.req_i & ~bus.we_i) ? rd_mux : '0;
        end
    end

    led_pwm_gen #(
        .PrescalerWidth (PrescalerWidth),
        .PwmWidth       (PwmWidth),
        .BlinkDivLog2   (BlinkDivLog2)
    ) u_pwm_gen (
        .clk_sys       (clk_sys),
        .rst_sys_n     (rst_sys_n),
        .prescale      (prescale_reg),
        .duty          (duty_reg),
        .clr_prescaler (prescale_clr),
        .pwm_on        (pwm_on),
        .blink_phase   (blink_phase)
    );

    for (genvar gi = 0; gi < NumLeds; gi++) begin : g_led
        assign led_next[gi] = led_out_reg[gi]
                            & (~ctrl_reg[CTRL_PWM_EN] | pwm_on)
                            & (~ctrl_reg[CTRL_BLINK_EN] | ~blink_mask_reg[gi] | blink_phase);
    end

    assign bus.gnt_o    = bus.req_i;
    assign bus.rvalid_o = rvalid_reg;
    assign bus.err_o    = err_reg;
    assign bus.rdata_o  = rdata_reg;
    assign led_o        = led_reg;

endmodule

// File: tb/tb_led_gpio_periph.sv
// Randomized and directed bench for led_gpio_periph against a cycle model
// built from the register map and counter rules with plain integer arithmetic.
module tb_led_gpio_periph;

    localparam int N = 8;

    logic         clk_sys   = 1'b0;
    logic         rst_sys_n = 1'b1;
    logic [N-1:0] led_o;
    int           checks    = 0;
    int           failures  = 0;
    bit           cmp_en    = 1'b0;

    always #5 clk_sys = ~clk_sys;

    led_gpio_if bus ();

    led_gpio_periph #(
        .NumLeds        (N),
        .PrescalerWidth (16),
        .PwmWidth       (8),
        .BlinkDivLog2   (6)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus       (bus),
        .led_o     (led_o)
    );

    typedef struct packed {
        logic [31:0] ctrl;
        logic [31:0] led;
        logic [31:0] presc;
        logic [31:0] duty;
        logic [31:0] mask;
        logic [31:0] pcnt;
        logic [31:0] pwm;
        logic [31:0] blink;
        logic [31:0] phase;
        logic [31:0] rvalid;
        logic [31:0] err;
        logic [31:0] rdata;
        logic [31:0] led_o;
    } model_t;

    model_t m = '0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endfunction

    // One clock of the peripheral as seen from outside: outputs from the
    // old state, then the register write and the timebase advance.
    function automatic model_t step(model_t s, logic req, logic we, logic [3:0] be,
                                    logic [31:0] addr, logic [31:0] wd);
        model_t      n = s;
        logic [31:0] bm;
        logic [31:0] wm;
        logic [7:0]  off;
        bit          on;
        bit          tick;
        bit          valid;
        bm  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wm  = wd & bm;
        off = addr[7:0];
        on  = (s.pwm < s.duty) || (s.duty == 255);
        n.led_o = 0;
        for (int i = 0; i < N; i++)
            n.led_o[i] = s.led[i] & (!s.ctrl[0] | on) & (!s.ctrl[1] | !s.mask[i] | s.phase[0]);
        valid    = off inside {8'h00, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};
        n.rvalid = {31'd0, req};
        n.err    = 0;
        n.rdata  = 0;
        if (req && !valid) begin
            n.err = 1;
        end else if (req && !we) begin
            case (off)
                8'h00:   n.rdata = s.ctrl;
                8'h10:   n.rdata = s.led;
                8'h1C:   n.rdata = s.presc;
                8'h20:   n.rdata = s.duty;
                8'h24:   n.rdata = s.mask;
                default: n.rdata = 0;
            endcase
        end else if (req && we) begin
            case (off)
                8'h00:   n.ctrl  = ((s.ctrl & ~bm) | wm) & 32'h3;
                8'h10:   n.led   = ((s.led & ~bm) | wm) & 32'hFF;
                8'h14:   n.led   = s.led | (wm & 32'hFF);
                8'h18:   n.led   = s.led & ~wm;
                8'h1C:   n.presc = ((s.presc & ~bm) | wm) & 32'hFFFF;
                8'h20:   n.duty  = ((s.duty & ~bm) | wm) & 32'hFF;
                8'h24:   n.mask  = ((s.mask & ~bm) | wm) & 32'hFF;
                default: ;
            endcase
        end
        tick = (s.pcnt == s.presc);
        if (req && we && off == 8'h1C && be != 0) n.pcnt = 0;
        else n.pcnt = tick ? 0 : s.pcnt + 1;
        if (tick) begin
            n.pwm = (s.pwm + 1) % 256;
            if (s.pwm == 255) begin
                n.blink = (s.blink + 1) % 64;
                if (s.blink == 63) n.phase = s.phase ^ 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) m <= '0;
        else m <= step(m, bus.req_i, bus.we_i, bus.be_i, bus.addr_i, bus.wdata_i);
    end

    always @(negedge clk_sys) begin
        if (cmp_en) begin
            chk("cyc_rvalid", {31'd0, bus.rvalid_o}, m.rvalid);
            chk("cyc_err", {31'd0, bus.err_o}, m.err);
            if (m.rvalid[0]) chk("cyc_rdata", bus.rdata_o, m.rdata);
            chk("cyc_led", 32'(led_o), m.led_o);
        end
    end

    task automatic xfer(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output bit err, output bit rv);
        @(negedge clk_sys);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.be_i    = be;
        bus.addr_i  = addr;
        bus.wdata_i = wd;
        #1;
        chk("gnt", {31'd0, bus.gnt_o}, 32'd1);
        @(negedge clk_sys);
        rd  = bus.rdata_o;
        err = bus.err_o;
        rv  = bus.rvalid_o;
        bus.req_i = 1'b0;
        bus.we_i  = 1'b0;
        $display("xfer %s addr=%h be=%h wdata=%h rdata=%h err=%0d rvalid=%0d",
                 we ? "WR" : "RD", addr, be, wd, rd, err, rv);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        bit          e;
        bit          v;
        xfer(1'b1, addr, 4'hF, wd, rd, e, v);
    endtask

    task automatic rd_expect(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bit          e;
        bit          v;
        xfer(1'b0, addr, 4'hF, 32'd0, rd, e, v);
        chk({name, "_rvalid"}, {31'd0, v}, 32'd1);
        chk({name, "_err"}, {31'd0, e}, 32'd0);
        chk(name, rd, exp);
    endtask

    logic [7:0] offs [12] = '{8'h00, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24,
                              8'h08, 8'h12, 8'h28, 8'h11, 8'hFC};

    initial begin
        logic [31:0] rd;
        bit          e;
        bit          v;
        int          cnt;
        int          n;
        bit          steady;
        logic        prev;

        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.be_i    = 4'h0;
        bus.addr_i  = 32'd0;
        bus.wdata_i = 32'd0;
        #1 rst_sys_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk_sys);
        rst_sys_n = 1'b1;

        // Reset state
        chk("rst_led", 32'(led_o), 32'd0);
        for (int i = 0; i < 7; i++) rd_expect("rst_read", {24'd0, offs[i]}, 32'd0);

        // Legacy register path: led follows LED_OUT two edges after the request
        xfer(1'b1, 32'h10, 4'hF, 32'h5A, rd, e, v);
        chk("led_lag", 32'(led_o), 32'd0);
        @(negedge clk_sys);
        chk("led_5a", 32'(led_o), 32'h5A);
        rd_expect("rd_led_5a", 32'h10, 32'h5A);

        // Set/clear
        wr(32'h10, 32'h0F);
        wr(32'h14, 32'hF0);
        wr(32'h18, 32'h03);
        rd_expect("setclr", 32'h10, 32'hFC);
        rd_expect("rd_set_zero", 32'h14, 32'h0);

        // Errors leave state untouched
        xfer(1'b0, 32'h08, 4'hF, 32'd0, rd, e, v);
        chk("err08", {30'd0, v, e}, 32'd3);
        xfer(1'b0, 32'h12, 4'hF, 32'd0, rd, e, v);
        chk("err12", {30'd0, v, e}, 32'd3);
        xfer(1'b1, 32'h11, 4'hF, 32'h00, rd, e, v);
        chk("err11_wr", {30'd0, v, e}, 32'd3);
        rd_expect("err_nochange", 32'h10, 32'hFC);

        // Zero byte-enable write is a silent no-op; partial lanes only touch their bytes
        xfer(1'b1, 32'h10, 4'h0, 32'hFF, rd, e, v);
        chk("be0_err", {31'd0, e}, 32'd0);
        rd_expect("be0_nochange", 32'h10, 32'hFC);
        xfer(1'b1, 32'h1C, 4'h2, 32'h1234, rd, e, v);
        rd_expect("be2_presc", 32'h1C, 32'h1200);

        // Random traffic checked cycle by cycle against the model
        for (int t = 0; t < 1500; t++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  b;
            a = {24'd0, offs[$urandom_range(0, 11)]};
            d = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if (a[7:0] == 8'h1C) d = $urandom_range(0, 4);
            xfer($urandom_range(0, 1) == 1, a, b, d, rd, e, v);
            repeat ($urandom_range(0, 2)) @(negedge clk_sys);
        end

        // PWM duty
        wr(32'h24, 32'h00);
        wr(32'h1C, 32'h00);
        wr(32'h20, 32'h40);
        wr(32'h10, 32'h01);
        wr(32'h00, 32'h01);
        @(negedge clk_sys);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_sys);
            cnt += int'(led_o[0]);
        end
        chk("pwm_40", cnt, 64);
        wr(32'h20, 32'hFF);
        @(negedge clk_sys);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_sys);
            cnt += int'(led_o[0]);
        end
        chk("pwm_ff", cnt, 256);
        wr(32'h20, 32'h00);
        @(negedge clk_sys);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_sys);
            cnt += int'(led_o[0]);
        end
        chk("pwm_00", cnt, 0);

        // Blink period
        wr(32'h20, 32'hFF);
        wr(32'h24, 32'h01);
        wr(32'h10, 32'h03);
        wr(32'h00, 32'h02);
        @(negedge clk_sys);
        prev = led_o[0];
        n = 0;
        while (led_o[0] == prev && n < 17000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("blink_edge_seen", {31'd0, n < 17000}, 32'd1);
        prev   = led_o[0];
        n      = 0;
        steady = 1'b1;
        while (led_o[0] == prev && n < 17000) begin
            @(negedge clk_sys);
            n++;
            if (led_o[1] !== 1'b1) steady = 1'b0;
        end
        chk("blink_period", n, 16384);
        chk("blink_led1_steady", {31'd0, steady}, 32'd1);

        // Reset during a write request: no response, everything cleared
        @(negedge clk_sys);
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.be_i    = 4'hF;
        bus.addr_i  = 32'h10;
        bus.wdata_i = 32'hAA;
        #2 rst_sys_n = 1'b0;
        bus.req_i = 1'b0;
        bus.we_i  = 1'b0;
        $display("xfer WR addr=00000010 wdata=000000aa cut by reset");
        repeat (2) @(negedge clk_sys);
        rst_sys_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys);
            cnt += int'(bus.rvalid_o);
            chk("rst_mid_led", 32'(led_o), 32'd0);
        end
        chk("rst_mid_no_rvalid", cnt, 0);
        for (int i = 0; i < 7; i++) rd_expect("rst_mid_read", {24'd0, offs[i]}, 32'd0);

        repeat (2) @(negedge clk_sys);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
